gpr_master: RTL

Bus-side initiator for the general purpose register file. It accepts register operations on a valid/ready request port and drives the register file's packed address, data, read-strobe and write-strobe inputs. For three-operand reads it captures the file's registered sum and returns it on a valid/ready response port. After every reset it clears all registers to zero before taking requests.

---
 rtl/gpr_master.sv | 167 ++++++++++++++++
 1 files changed

// File: rtl/gpr_master.sv
// gpr_master: request/response front end for the general purpose register file.
// After reset it clears every register, then it turns each accepted request into
// one write strobe, or into one read strobe followed by a returned sum.
module gpr_master #(
  parameter int unsigned DATA_W = 14,
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned REG_W  = 4,
  parameter int unsigned REG_N  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_wr,
  input  logic [REG_W-1:0]  req_ra,
  input  logic [REG_W-1:0]  req_rb,
  input  logic [REG_W-1:0]  req_rc,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              init_done,
  output logic [ADDR_W-1:0] gpr_address,
  output logic [DATA_W-1:0] gpr_data_in,
  output logic              gpr_rd,
  output logic              gpr_wr,
  input  logic [DATA_W-1:0] gpr_data_out
);

  // r_state names the phase whose outputs are being set up for the next cycle.
  // Every output comes straight from a register that is loaded at the same edge
  // as the state. Request fields are captured into those output registers at
  // acceptance, so later changes on the request port have no effect.
  typedef enum logic [2:0] {
    S_INIT,
    S_IDLE,
    S_WRITE,
    S_ISSUE,
    S_CAPTURE,
    S_RESP
  } state_t;

  state_t              r_state;
  state_t              w_state;
  logic [REG_W-1:0]    r_cnt;
  logic [REG_W-1:0]    w_cnt;

  logic                r_req_ready,   w_req_ready;
  logic                r_resp_valid,  w_resp_valid;
  logic [DATA_W-1:0]   r_resp_data,   w_resp_data;
  logic                r_init_done,   w_init_done;
  logic [ADDR_W-1:0]   r_gpr_address, w_gpr_address;
  logic [DATA_W-1:0]   r_gpr_data_in, w_gpr_data_in;
  logic                r_gpr_rd,      w_gpr_rd;
  logic                r_gpr_wr,      w_gpr_wr;

  // State, sweep counter and registered outputs; rst restarts the clear sweep.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= S_INIT;
      r_cnt         <= '0;
      r_req_ready   <= 1'b0;
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_init_done   <= 1'b0;
      r_gpr_address <= '0;
      r_gpr_data_in <= '0;
      r_gpr_rd      <= 1'b0;
      r_gpr_wr      <= 1'b0;
    end else begin
      r_state       <= w_state;
      r_cnt         <= w_cnt;
      r_req_ready   <= w_req_ready;
      r_resp_valid  <= w_resp_valid;
      r_resp_data   <= w_resp_data;
      r_init_done   <= w_init_done;
      r_gpr_address <= w_gpr_address;
      r_gpr_data_in <= w_gpr_data_in;
      r_gpr_rd      <= w_gpr_rd;
      r_gpr_wr      <= w_gpr_wr;
    end
  end

  // Next state and next output values; strobes and ready default low, data holds.
  always_comb begin
    w_state       = r_state;
    w_cnt         = r_cnt;
    w_req_ready   = 1'b0;
    w_resp_valid  = r_resp_valid;
    w_resp_data   = r_resp_data;
    w_init_done   = r_init_done;
    w_gpr_address = r_gpr_address;
    w_gpr_data_in = r_gpr_data_in;
    w_gpr_rd      = 1'b0;
    w_gpr_wr      = 1'b0;

    case (r_state)
      S_INIT: begin
        w_gpr_wr      = 1'b1;
        w_gpr_address = ADDR_W'(r_cnt);
        w_gpr_data_in = '0;
        w_cnt         = r_cnt + REG_W'(1);
        if (r_cnt == REG_W'(REG_N - 1)) begin
          w_state = S_IDLE;
        end
      end

      S_IDLE: begin
        w_req_ready = 1'b1;
        w_init_done = 1'b1;
        if (req_valid && r_req_ready) begin
          w_req_ready = 1'b0;
          if (req_wr) begin
            // Write index sits in the low field with every higher bit clear.
            w_gpr_wr      = 1'b1;
            w_gpr_address = ADDR_W'(req_rc);
            w_gpr_data_in = req_wdata;
            w_state       = S_WRITE;
          end else begin
            w_gpr_rd      = 1'b1;
            w_gpr_address = ADDR_W'({req_ra, req_rb, req_rc});
            w_state       = S_ISSUE;
          end
        end
      end

      S_WRITE: begin
        w_req_ready = 1'b1;
        w_state     = S_IDLE;
      end

      S_ISSUE: begin
        w_state = S_CAPTURE;
      end

      S_CAPTURE: begin
        // The file registered the sum at the end of the strobe cycle.
        w_resp_valid = 1'b1;
        w_resp_data  = gpr_data_out;
        w_state      = S_RESP;
      end

      S_RESP: begin
        if (r_resp_valid && resp_ready) begin
          w_resp_valid = 1'b0;
          w_req_ready  = 1'b1;
          w_state      = S_IDLE;
        end
      end

      default: begin
        w_state = S_INIT;
        w_cnt   = '0;
      end
    endcase
  end

  assign req_ready   = r_req_ready;
  assign resp_valid  = r_resp_valid;
  assign resp_data   = r_resp_data;
  assign init_done   = r_init_done;
  assign gpr_address = r_gpr_address;
  assign gpr_data_in = r_gpr_data_in;
  assign gpr_rd      = r_gpr_rd;
  assign gpr_wr      = r_gpr_wr;

endmodule
